// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants and the ID->EX payload layout.
package riscv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned OPC_W = 7;

  localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  instr;
    logic [XLEN-1:0]  rs1_val;
    logic [XLEN-1:0]  rs2_val;
    logic [XLEN-1:0]  imm;
    logic [REG_W-1:0] rd;
  } ex_payload_t;

  // Stores and branches carry no destination register.
  function automatic logic has_rd(input logic [OPC_W-1:0] opc);
    return (opc != OP_STORE) && (opc != OP_BRANCH);
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Sign-extended immediate extraction for RV32I instruction formats.
module imm_gen
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] imm
);

  logic [OPC_W-1:0] opc;
  assign opc = instr[6:0];

  always_comb begin
    imm = '0;
    case (opc)
      OP_IMM, OP_LOAD, OP_JALR:
        imm = {{20{instr[31]}}, instr[31:20]};
      OP_STORE:
        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OP_BRANCH:
        imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm = {instr[31:12], 12'b0};
      OP_JAL:
        imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: operand read with writeback bypass, immediate generation,
// load-use interlock and a registered valid/ready hand-off to execute.
module id_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = riscv_pkg::XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_instr,
  output logic [REG_W-1:0] rf_a1,
  output logic [REG_W-1:0] rf_a2,
  input  logic [XLEN-1:0]  rf_rd1,
  input  logic [XLEN-1:0]  rf_rd2,
  input  logic             wb_we,
  input  logic [REG_W-1:0] wb_a3,
  input  logic [XLEN-1:0]  wb_wd3,
  input  logic             flush,
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_instr,
  output logic [XLEN-1:0]  ex_rs1_val,
  output logic [XLEN-1:0]  ex_rs2_val,
  output logic [XLEN-1:0]  ex_imm,
  output logic [REG_W-1:0] ex_rd,
  output logic [15:0]      perf_stall_cnt
);

  logic [REG_W-1:0] rs1, rs2;
  logic [XLEN-1:0]  rs1_val, rs2_val, imm;
  logic             hazard, accept, stall;
  ex_payload_t      ex_q, ex_d;
  logic             valid_q;
  logic [15:0]      stall_cnt_q;

  assign rs1   = in_instr[19:15];
  assign rs2   = in_instr[24:20];
  assign rf_a1 = rs1;
  assign rf_a2 = rs2;

  // Writeback bypass; x0 always reads as zero so wb_a3==0 can never match.
  always_comb begin
    rs1_val = rf_rd1;
    if (rs1 == '0)
      rs1_val = '0;
    else if (wb_we && (wb_a3 == rs1))
      rs1_val = wb_wd3;
  end

  always_comb begin
    rs2_val = rf_rd2;
    if (rs2 == '0)
      rs2_val = '0;
    else if (wb_we && (wb_a3 == rs2))
      rs2_val = wb_wd3;
  end

  imm_gen u_imm_gen (
    .instr (in_instr),
    .imm   (imm)
  );

  // Load in execute whose result the incoming instruction needs.
  assign hazard = valid_q && (ex_q.instr[6:0] == OP_LOAD) && (ex_q.rd != '0) &&
                  ((ex_q.rd == rs1) || (ex_q.rd == rs2));

  assign in_ready = !rst && (!valid_q || ex_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;
  assign stall    = hazard && ex_ready && !flush;

  always_comb begin
    ex_d         = ex_q;
    ex_d.pc      = in_pc;
    ex_d.instr   = in_instr;
    ex_d.rs1_val = rs1_val;
    ex_d.rs2_val = rs2_val;
    ex_d.imm     = imm;
    ex_d.rd      = has_rd(in_instr[6:0]) ? in_instr[11:7] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      ex_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (flush)
        valid_q <= 1'b0;
      else if (accept) begin
        valid_q <= 1'b1;
        ex_q    <= ex_d;
      end else if (ex_ready)
        valid_q <= 1'b0;

      if (stall && (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign ex_valid       = valid_q;
  assign ex_pc          = ex_q.pc;
  assign ex_instr       = ex_q.instr;
  assign ex_rs1_val     = ex_q.rs1_val;
  assign ex_rs2_val     = ex_q.rs2_val;
  assign ex_imm         = ex_q.imm;
  assign ex_rd          = ex_q.rd;
  assign perf_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode vector table plus interlock, hold, flush and reset sequences.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc, in_instr;
  logic [4:0]  rf_a1, rf_a2;
  logic [31:0] rf_rd1, rf_rd2;
  logic        wb_we;
  logic [4:0]  wb_a3;
  logic [31:0] wb_wd3;
  logic        flush;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_pc, ex_instr, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]  ex_rd;
  logic [15:0] perf_stall_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_stage #(.XLEN(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pc          (in_pc),
    .in_instr       (in_instr),
    .rf_a1          (rf_a1),
    .rf_a2          (rf_a2),
    .rf_rd1         (rf_rd1),
    .rf_rd2         (rf_rd2),
    .wb_we          (wb_we),
    .wb_a3          (wb_a3),
    .wb_wd3         (wb_wd3),
    .flush          (flush),
    .ex_valid       (ex_valid),
    .ex_ready       (ex_ready),
    .ex_pc          (ex_pc),
    .ex_instr       (ex_instr),
    .ex_rs1_val     (ex_rs1_val),
    .ex_rs2_val     (ex_rs2_val),
    .ex_imm         (ex_imm),
    .ex_rd          (ex_rd),
    .perf_stall_cnt (perf_stall_cnt)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic [4:0]  e_a1;
    logic [4:0]  e_a2;
    logic [31:0] e_rs1;
    logic [31:0] e_rs2;
    logic [31:0] e_imm;
    logic [4:0]  e_rd;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  localparam logic [31:0] LW_X6  = 32'h00012303;
  localparam logic [31:0] ADD_X7 = 32'h001303B3;
  localparam logic [31:0] ADDI   = 32'h7FF08293;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_instr = 32'h0;
    in_pc    = 32'h0;
    rf_rd1   = 32'h0;
    rf_rd2   = 32'h0;
    wb_we    = 1'b0;
    wb_a3    = 5'd0;
    wb_wd3   = 32'h0;
    flush    = 1'b0;
  endtask

  initial begin
    //          instr         rd1           rd2           we    a3     wd3           a1     a2     rs1           rs2           imm           rd
    vecs[0]  = '{ADDI,         32'h1,        32'hAAAA,     1'b0, 5'd0,  32'h0,        5'd1,  5'd31, 32'h1,        32'hAAAA,     32'h000007FF, 5'd5};
    vecs[1]  = '{ADDI,         32'h1,        32'hAAAA,     1'b1, 5'd1,  32'hDEADBEEF, 5'd1,  5'd31, 32'hDEADBEEF, 32'hAAAA,     32'h000007FF, 5'd5};
    vecs[2]  = '{32'h7FF00293, 32'h55,       32'h66,       1'b1, 5'd0,  32'h1234,     5'd0,  5'd31, 32'h0,        32'h66,       32'h000007FF, 5'd5};
    vecs[3]  = '{32'hFE000EE3, 32'h11,       32'h22,       1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        32'hFFFFFFFC, 5'd0};
    vecs[4]  = '{32'hFE512C23, 32'h100,      32'h200,      1'b1, 5'd5,  32'h99,       5'd2,  5'd5,  32'h100,      32'h99,       32'hFFFFFFF8, 5'd0};
    vecs[5]  = '{32'h12345537, 32'h11,       32'h22,       1'b1, 5'd9,  32'hBAD,      5'd8,  5'd3,  32'h11,       32'h22,       32'h12345000, 5'd10};
    vecs[6]  = '{32'h001000EF, 32'h77,       32'h66,       1'b0, 5'd0,  32'h0,        5'd0,  5'd1,  32'h0,        32'h66,       32'h00000800, 5'd1};
    vecs[7]  = '{32'hFFDFF06F, 32'h1,        32'h2,        1'b0, 5'd0,  32'h0,        5'd31, 5'd29, 32'h1,        32'h2,        32'hFFFFFFFC, 5'd0};
    vecs[8]  = '{ADD_X7,       32'h3,        32'h4,        1'b0, 5'd6,  32'hFF,       5'd6,  5'd1,  32'h3,        32'h4,        32'h0,        5'd7};
    vecs[9]  = '{32'hFFFFF197, 32'h5,        32'h6,        1'b1, 5'd31, 32'hCAFE,     5'd31, 5'd31, 32'hCAFE,     32'hCAFE,     32'hFFFFF000, 5'd3};
    vecs[10] = '{32'hFF0280E7, 32'h123,      32'h456,      1'b0, 5'd0,  32'h0,        5'd5,  5'd16, 32'h123,      32'h456,      32'hFFFFFFF0, 5'd1};

    idle_inputs();
    ex_ready = 1'b1;
    rst      = 1'b1;
    in_valid = 1'b1;
    in_instr = ADDI;
    step();
    step();
    chk("reset_in_ready", 32'(in_ready), 32'h0);
    chk("reset_ex_valid", 32'(ex_valid), 32'h0);
    chk("reset_stall_cnt", 32'(perf_stall_cnt), 32'h0);
    rst = 1'b0;
    idle_inputs();
    step();

    // Single-instruction decode table.
    for (int i = 0; i < NV; i++) begin
      in_valid = 1'b1;
      in_pc    = 32'h1000 + 32'(i * 4);
      in_instr = vecs[i].instr;
      rf_rd1   = vecs[i].rd1;
      rf_rd2   = vecs[i].rd2;
      wb_we    = vecs[i].we;
      wb_a3    = vecs[i].a3;
      wb_wd3   = vecs[i].wd3;
      #1;
      chk($sformatf("v%0d_rf_a1", i), 32'(rf_a1), 32'(vecs[i].e_a1));
      chk($sformatf("v%0d_rf_a2", i), 32'(rf_a2), 32'(vecs[i].e_a2));
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'h1);
      step();
      chk($sformatf("v%0d_ex_valid", i), 32'(ex_valid), 32'h1);
      chk($sformatf("v%0d_ex_pc", i), ex_pc, 32'h1000 + 32'(i * 4));
      chk($sformatf("v%0d_ex_instr", i), ex_instr, vecs[i].instr);
      chk($sformatf("v%0d_rs1", i), ex_rs1_val, vecs[i].e_rs1);
      chk($sformatf("v%0d_rs2", i), ex_rs2_val, vecs[i].e_rs2);
      chk($sformatf("v%0d_imm", i), ex_imm, vecs[i].e_imm);
      chk($sformatf("v%0d_rd", i), 32'(ex_rd), 32'(vecs[i].e_rd));
      idle_inputs();
      step();
      chk($sformatf("v%0d_drain", i), 32'(ex_valid), 32'h0);
      chk($sformatf("v%0d_keep_instr", i), ex_instr, vecs[i].instr);
    end
    chk("no_stalls_yet", 32'(perf_stall_cnt), 32'h0);

    // Load-use interlock: lw x6 then add x7,x6,x1.
    in_valid = 1'b1; in_pc = 32'h2000; in_instr = LW_X6;
    step();
    chk("lu_lw_valid", 32'(ex_valid), 32'h1);
    in_pc = 32'h2004; in_instr = ADD_X7; rf_rd1 = 32'h10; rf_rd2 = 32'h20;
    #1;
    chk("lu_in_ready_low", 32'(in_ready), 32'h0);
    step();
    chk("lu_bubble", 32'(ex_valid), 32'h0);
    chk("lu_stall_cnt", 32'(perf_stall_cnt), 32'h1);
    chk("lu_in_ready_back", 32'(in_ready), 32'h1);
    chk("lu_bubble_keeps_lw", ex_instr, LW_X6);
    step();
    chk("lu_add_valid", 32'(ex_valid), 32'h1);
    chk("lu_add_instr", ex_instr, ADD_X7);
    chk("lu_add_rd", 32'(ex_rd), 32'd7);
    chk("lu_add_rs1", ex_rs1_val, 32'h10);
    chk("lu_stall_once", 32'(perf_stall_cnt), 32'h1);

    // Backpressure hold for three cycles with a pending input.
    ex_ready = 1'b0; in_pc = 32'h3000; in_instr = ADDI; rf_rd1 = 32'h999;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("hold%0d_in_ready", c), 32'(in_ready), 32'h0);
      step();
      chk($sformatf("hold%0d_valid", c), 32'(ex_valid), 32'h1);
      chk($sformatf("hold%0d_pc", c), ex_pc, 32'h2004);
      chk($sformatf("hold%0d_instr", c), ex_instr, ADD_X7);
      chk($sformatf("hold%0d_rs1", c), ex_rs1_val, 32'h10);
      chk($sformatf("hold%0d_rs2", c), ex_rs2_val, 32'h20);
      chk($sformatf("hold%0d_imm", c), ex_imm, 32'h0);
      chk($sformatf("hold%0d_rd", c), 32'(ex_rd), 32'd7);
    end

    // Flush while stalled downstream: drops the entry, does not take the input.
    flush = 1'b1;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'h0);
    step();
    chk("flush_valid", 32'(ex_valid), 32'h0);
    chk("flush_not_consumed", ex_instr, ADD_X7);
    chk("flush_cnt", 32'(perf_stall_cnt), 32'h1);
    idle_inputs();
    ex_ready = 1'b1;
    step();

    // Load-use under backpressure, then flush over a stall.
    in_valid = 1'b1; in_pc = 32'h4000; in_instr = LW_X6;
    step();
    chk("lu2_lw_valid", 32'(ex_valid), 32'h1);
    ex_ready = 1'b0; in_pc = 32'h4004; in_instr = ADD_X7; rf_rd1 = 32'h31; rf_rd2 = 32'h32;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk($sformatf("lu2_hold%0d_ready", c), 32'(in_ready), 32'h0);
      step();
      chk($sformatf("lu2_hold%0d_instr", c), ex_instr, LW_X6);
      chk($sformatf("lu2_hold%0d_cnt", c), 32'(perf_stall_cnt), 32'h1);
    end
    ex_ready = 1'b1; flush = 1'b1;
    step();
    chk("lu2_flush_valid", 32'(ex_valid), 32'h0);
    chk("lu2_flush_cnt", 32'(perf_stall_cnt), 32'h1);
    chk("lu2_flush_instr", ex_instr, LW_X6);
    flush = 1'b0;
    #1;
    chk("lu2_ready_after", 32'(in_ready), 32'h1);
    step();
    chk("lu2_add_valid", 32'(ex_valid), 32'h1);
    chk("lu2_add_pc", ex_pc, 32'h4004);
    chk("lu2_add_rs2", ex_rs2_val, 32'h32);

    // Reset beats flush and accept in the same cycle.
    rst = 1'b1; flush = 1'b1; in_valid = 1'b1; in_instr = ADDI;
    #1;
    chk("rst2_in_ready", 32'(in_ready), 32'h0);
    step();
    chk("rst2_valid", 32'(ex_valid), 32'h0);
    chk("rst2_pc", ex_pc, 32'h0);
    chk("rst2_instr", ex_instr, 32'h0);
    chk("rst2_rs1", ex_rs1_val, 32'h0);
    chk("rst2_rs2", ex_rs2_val, 32'h0);
    chk("rst2_imm", ex_imm, 32'h0);
    chk("rst2_rd", 32'(ex_rd), 32'h0);
    chk("rst2_cnt", 32'(perf_stall_cnt), 32'h0);
    rst = 1'b0;
    idle_inputs();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
